// File: rtl/i2c_txrx_fifo.sv
// i2c_txrx_fifo: TX and RX byte FIFOs between the I2C APB registers and the protocol core.
// Optional per-FIFO flush inputs are enabled by defining I2C_FIFO_FLUSH_EN.
module i2c_txrx_fifo #(
    parameter int DW = 8,
    parameter int AW = 3
) (
    input  logic          pclk,
    input  logic          prst_n,
`ifdef I2C_FIFO_FLUSH_EN
    input  logic          txff_flush,
    input  logic          rxff_flush,
`endif
    input  logic          txff_wr,
    input  logic [DW-1:0] txff_wdata,
    output logic          txff_txnf,
    input  logic          txff_rd,
    output logic [DW-1:0] txff_rdata,
    output logic          txff_txne,
    input  logic          rxff_wr,
    input  logic [DW-1:0] rxff_wdata,
    output logic          rxff_rxnf,
    input  logic          rxff_rd,
    output logic [DW-1:0] rxff_data,
    output logic          rxff_rxne,
    output logic          rxff_ov
);
    localparam int          DEPTH   = 1 << AW;
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [DW-1:0] tx_mem [DEPTH];
    logic [DW-1:0] rx_mem [DEPTH];

    logic [AW:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [AW:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic        rx_ov_q, rx_ov_d;

    logic tx_empty, tx_full, tx_push, tx_pop, tx_flush;
    logic rx_empty, rx_full, rx_push, rx_pop, rx_flush;

`ifdef I2C_FIFO_FLUSH_EN
    assign tx_flush = txff_flush;
    assign rx_flush = rxff_flush;
`else
    assign tx_flush = 1'b0;
    assign rx_flush = 1'b0;
`endif

    // Full: same slot, opposite wrap bit.
    assign tx_empty = (tx_wr_q == tx_rd_q);
    assign tx_full  = (tx_wr_q[AW] != tx_rd_q[AW]) && (tx_wr_q[AW-1:0] == tx_rd_q[AW-1:0]);
    assign rx_empty = (rx_wr_q == rx_rd_q);
    assign rx_full  = (rx_wr_q[AW] != rx_rd_q[AW]) && (rx_wr_q[AW-1:0] == rx_rd_q[AW-1:0]);

    // A pop on a full FIFO frees the slot the concurrent push writes into.
    assign tx_pop  = txff_rd && !tx_empty && !tx_flush;
    assign tx_push = txff_wr && (!tx_full || tx_pop) && !tx_flush;
    assign rx_pop  = rxff_rd && !rx_empty && !rx_flush;
    assign rx_push = rxff_wr && (!rx_full || rx_pop) && !rx_flush;

    always_comb begin
        tx_wr_d = tx_wr_q;
        tx_rd_d = tx_rd_q;
        if (tx_flush) begin
            tx_wr_d = '0;
            tx_rd_d = '0;
        end else begin
            if (tx_push) tx_wr_d = tx_wr_q + PTR_ONE;
            if (tx_pop)  tx_rd_d = tx_rd_q + PTR_ONE;
        end
    end

    always_comb begin
        rx_wr_d = rx_wr_q;
        rx_rd_d = rx_rd_q;
        rx_ov_d = rx_ov_q;
        if (rx_flush) begin
            rx_wr_d = '0;
            rx_rd_d = '0;
            rx_ov_d = 1'b0;
        end else begin
            if (rx_push) rx_wr_d = rx_wr_q + PTR_ONE;
            if (rx_pop)  rx_rd_d = rx_rd_q + PTR_ONE;
            // Dropped byte sets the flag; set takes priority over the pop clear.
            if (rxff_wr && rx_full && !rx_pop) rx_ov_d = 1'b1;
            else if (rx_pop)                   rx_ov_d = 1'b0;
        end
    end

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            tx_wr_q <= '0;
            tx_rd_q <= '0;
            rx_wr_q <= '0;
            rx_rd_q <= '0;
            rx_ov_q <= 1'b0;
        end else begin
            tx_wr_q <= tx_wr_d;
            tx_rd_q <= tx_rd_d;
            rx_wr_q <= rx_wr_d;
            rx_rd_q <= rx_rd_d;
            rx_ov_q <= rx_ov_d;
        end
    end

    always_ff @(posedge pclk) begin
        if (tx_push) tx_mem[tx_wr_q[AW-1:0]] <= txff_wdata;
        if (rx_push) rx_mem[rx_wr_q[AW-1:0]] <= rxff_wdata;
    end

    assign txff_txnf  = !tx_full;
    assign txff_txne  = !tx_empty;
    assign txff_rdata = tx_empty ? '0 : tx_mem[tx_rd_q[AW-1:0]];
    assign rxff_rxnf  = !rx_full;
    assign rxff_rxne  = !rx_empty;
    assign rxff_data  = rx_empty ? '0 : rx_mem[rx_rd_q[AW-1:0]];
    assign rxff_ov    = rx_ov_q;

endmodule

// File: tb/tb_i2c_txrx_fifo.sv
// Scoreboard bench for i2c_txrx_fifo: queue models of both FIFOs checked against flags and head data.
module tb_i2c_txrx_fifo;
    localparam int DEPTH = 8;

    logic       pclk = 1'b0;
    logic       prst_n;
    logic       txff_wr, txff_rd, rxff_wr, rxff_rd;
    logic [7:0] txff_wdata, rxff_wdata;
    logic       txff_txnf, txff_txne, rxff_rxnf, rxff_rxne, rxff_ov;
    logic [7:0] txff_rdata, rxff_data;
`ifdef I2C_FIFO_FLUSH_EN
    logic       txff_flush, rxff_flush;
`endif

    int total = 0;
    int bad   = 0;

    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    bit         ov_m;

    always #5 pclk = ~pclk;

    i2c_txrx_fifo #(.DW(8), .AW(3)) dut (
        .pclk       (pclk),
        .prst_n     (prst_n),
`ifdef I2C_FIFO_FLUSH_EN
        .txff_flush (txff_flush),
        .rxff_flush (rxff_flush),
`endif
        .txff_wr    (txff_wr),
        .txff_wdata (txff_wdata),
        .txff_txnf  (txff_txnf),
        .txff_rd    (txff_rd),
        .txff_rdata (txff_rdata),
        .txff_txne  (txff_txne),
        .rxff_wr    (rxff_wr),
        .rxff_wdata (rxff_wdata),
        .rxff_rxnf  (rxff_rxnf),
        .rxff_rd    (rxff_rd),
        .rxff_data  (rxff_data),
        .rxff_rxne  (rxff_rxne),
        .rxff_ov    (rxff_ov)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string ph);
        chk({ph, "/txnf"}, 32'(txff_txnf), 32'(txq.size() < DEPTH));
        chk({ph, "/txne"}, 32'(txff_txne), 32'(txq.size() != 0));
        chk({ph, "/txrd"}, 32'(txff_rdata), (txq.size() != 0) ? 32'(txq[0]) : 32'h0);
        chk({ph, "/rxnf"}, 32'(rxff_rxnf), 32'(rxq.size() < DEPTH));
        chk({ph, "/rxne"}, 32'(rxff_rxne), 32'(rxq.size() != 0));
        chk({ph, "/rxd"},  32'(rxff_data), (rxq.size() != 0) ? 32'(rxq[0]) : 32'h0);
        chk({ph, "/ov"},   32'(rxff_ov),   32'(ov_m));
    endtask

    // Called at a falling edge: drives one cycle, scores pops, updates the model, checks after the edge.
    task automatic do_cycle(input bit tw, input logic [7:0] twd, input bit tr,
                            input bit rw, input logic [7:0] rwd, input bit rr, input string ph);
        bit tfull, rfull, tpop, rpop;
        logic [7:0] ex;
        txff_wr = tw; txff_wdata = twd; txff_rd = tr;
        rxff_wr = rw; rxff_wdata = rwd; rxff_rd = rr;
        #1;
        tfull = (txq.size() == DEPTH);
        rfull = (rxq.size() == DEPTH);
        tpop  = tr && (txq.size() != 0);
        rpop  = rr && (rxq.size() != 0);
        if (tpop) begin
            ex = txq.pop_front();
            chk({ph, "/txpop"}, 32'(txff_rdata), 32'(ex));
        end
        if (rpop) begin
            ex = rxq.pop_front();
            chk({ph, "/rxpop"}, 32'(rxff_data), 32'(ex));
        end
        if (tw && (!tfull || tpop)) txq.push_back(twd);
        if (rw && (!rfull || rpop)) rxq.push_back(rwd);
        if (rw && rfull && !rpop) ov_m = 1'b1;
        else if (rpop)            ov_m = 1'b0;
        @(posedge pclk);
        #1;
        txff_wr = 1'b0; txff_rd = 1'b0; rxff_wr = 1'b0; rxff_rd = 1'b0;
        check_state(ph);
        @(negedge pclk);
    endtask

    initial begin
        prst_n = 1'b0;
        txff_wr = 1'b0; txff_rd = 1'b0; txff_wdata = '0;
        rxff_wr = 1'b0; rxff_rd = 1'b0; rxff_wdata = '0;
`ifdef I2C_FIFO_FLUSH_EN
        txff_flush = 1'b0; rxff_flush = 1'b0;
`endif
        ov_m = 1'b0;
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        prst_n = 1'b1;
        check_state("reset");

        // TX fill, ignored overflow push, ordered drain
        for (int i = 1; i <= 8; i++) do_cycle(1'b1, 8'(i), 1'b0, 1'b0, 8'h0, 1'b0, "txfill");
        chk("tx_full_nf", 32'(txff_txnf), 32'h0);
        do_cycle(1'b1, 8'hFF, 1'b0, 1'b0, 8'h0, 1'b0, "tx9th");
        for (int i = 1; i <= 8; i++) do_cycle(1'b0, 8'h0, 1'b1, 1'b0, 8'h0, 1'b0, "txdrain");
        chk("tx_empty_rd", 32'(txff_rdata), 32'h0);

        // RX overflow then pop clears the flag
        for (int i = 0; i < 9; i++) do_cycle(1'b0, 8'h0, 1'b0, 1'b1, 8'(8'h10 + i), 1'b0, "rxfill");
        chk("rx_ov_set", 32'(rxff_ov), 32'h1);
        do_cycle(1'b0, 8'h0, 1'b0, 1'b0, 8'h0, 1'b1, "rxpop1");
        do_cycle(1'b0, 8'h0, 1'b0, 1'b1, 8'h19, 1'b0, "rxrefill");
        do_cycle(1'b0, 8'h0, 1'b0, 1'b1, 8'hAA, 1'b1, "rxfullpp");
        chk("rx_full_pp_ov", 32'(rxff_ov), 32'h0);
        for (int i = 0; i < 8; i++) do_cycle(1'b0, 8'h0, 1'b0, 1'b0, 8'h0, 1'b1, "rxdrain");

        // Simultaneous push/pop on empty
        do_cycle(1'b1, 8'h55, 1'b1, 1'b1, 8'h55, 1'b1, "emptypp");
        chk("emptypp_rxd", 32'(rxff_data), 32'h55);
        do_cycle(1'b0, 8'h0, 1'b1, 1'b0, 8'h0, 1'b1, "emptypp_pop");

        // Interleaved traffic across pointer wrap, occupancy held within 1..7
        for (int i = 0; i < 20; i++)
            do_cycle(1'b1, 8'(i), (txq.size() >= 3), 1'b1, 8'(i), (rxq.size() >= 5), "wrap");
        while (txq.size() != 0 || rxq.size() != 0)
            do_cycle(1'b0, 8'h0, 1'b1, 1'b0, 8'h0, 1'b1, "wrapdrain");

        // Asynchronous reset between edges
        for (int i = 0; i < 5; i++) do_cycle(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0, 8'h0, 1'b0, "preload");
        #2 prst_n = 1'b0;
        #1;
        chk("arst_txne", 32'(txff_txne), 32'h0);
        chk("arst_txnf", 32'(txff_txnf), 32'h1);
        chk("arst_txrd", 32'(txff_rdata), 32'h0);
        #1 prst_n = 1'b1;
        txq.delete(); rxq.delete(); ov_m = 1'b0;
        @(negedge pclk);
        check_state("postrst");
        do_cycle(1'b1, 8'h3C, 1'b0, 1'b0, 8'h0, 1'b0, "rst_push");
        do_cycle(1'b0, 8'h0, 1'b1, 1'b0, 8'h0, 1'b0, "rst_pop");

`ifdef I2C_FIFO_FLUSH_EN
        // Overflowed RX flushed together with a push: push discarded, flag cleared
        for (int i = 0; i < 9; i++) do_cycle(1'b0, 8'h0, 1'b0, 1'b1, 8'(8'h40 + i), 1'b0, "flfill");
        rxff_flush = 1'b1; rxff_wr = 1'b1; rxff_wdata = 8'h77;
        @(posedge pclk);
        #1;
        rxff_flush = 1'b0; rxff_wr = 1'b0;
        rxq.delete(); ov_m = 1'b0;
        check_state("flush");
        @(negedge pclk);
        do_cycle(1'b0, 8'h0, 1'b0, 1'b1, 8'h01, 1'b0, "flpush");
        do_cycle(1'b0, 8'h0, 1'b0, 1'b0, 8'h0, 1'b1, "flpop");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
